// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, forwarding selects, load/store funct3
// encodings and the hazard-controller FSM state.
package riscv_pkg;

  localparam int unsigned OPCODE_W = 7;

  localparam logic [OPCODE_W-1:0] RTYPE = 7'b0110011;
  localparam logic [OPCODE_W-1:0] ITYPE = 7'b0010011;
  localparam logic [OPCODE_W-1:0] ILOAD = 7'b0000011;
  localparam logic [OPCODE_W-1:0] STYPE = 7'b0100011;
  localparam logic [OPCODE_W-1:0] BTYPE = 7'b1100011;
  localparam logic [OPCODE_W-1:0] IJALR = 7'b1100111;
  localparam logic [OPCODE_W-1:0] JTYPE = 7'b1101111;
  localparam logic [OPCODE_W-1:0] LUI   = 7'b0110111;
  localparam logic [OPCODE_W-1:0] AUIPC = 7'b0010111;

  typedef enum logic [1:0] {
    FWD_NONE   = 2'b00,
    FWD_EX_MEM = 2'b01,
    FWD_MEM_WB = 2'b10
  } forward_t;

  typedef enum logic [2:0] {
    LOAD_LB  = 3'b000,
    LOAD_LH  = 3'b001,
    LOAD_LW  = 3'b010,
    LOAD_LBU = 3'b100,
    LOAD_LHU = 3'b101
  } load_t;

  typedef enum logic [2:0] {
    STORE_SB = 3'b000,
    STORE_SH = 3'b001,
    STORE_SW = 3'b010
  } store_t;

  typedef enum logic {
    RUN      = 1'b0,
    LD_STALL = 1'b1
  } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_mc_sat_counter.sv
// Saturating up-counter used for the hazard perf counters.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Pipeline hazard controller: redirects, multi-cycle load-use stalls,
// EX busy holds and data-memory freezes, plus stall/flush perf counters.
module hazard_ctrl_mc
  import riscv_pkg::*;
#(
  parameter int unsigned LOAD_USE_CYCLES = 1,
  parameter int unsigned REG_ADDR_W      = 5,
  parameter int unsigned PERF_CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [6:0]            opcode_id,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_load_inst,
  input  logic                  modify_pc_ex,
  input  logic                  ex_busy,
  input  logic                  dmem_wait,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  ex_mem_en,
  output logic                  if_id_flush,
  output logic                  im_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_flush,
  output logic                  mem_wb_flush,
  output logic                  load_stall,
  output logic [PERF_CNT_W-1:0] stall_cnt,
  output logic [PERF_CNT_W-1:0] flush_cnt
);

  localparam int unsigned LD_CNT_W = 3;
  localparam logic [LD_CNT_W-1:0] LD_INIT = LD_CNT_W'(LOAD_USE_CYCLES - 1);

  hz_state_t           state, state_nxt;
  logic [LD_CNT_W-1:0] ld_cnt, ld_cnt_nxt;
  logic                rs1_used, rs2_used, hz;
  logic                redirect_take;

  // Source-register usage by instruction format
  always_comb begin
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    unique case (opcode_id)
      RTYPE, STYPE, BTYPE: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      ITYPE, ILOAD, IJALR: rs1_used = 1'b1;
      default: ;
    endcase
  end

  assign hz = ex_load_inst && (ex_rd != '0) &&
              ((rs1_used && (ex_rd == id_rs1)) || (rs2_used && (ex_rd == id_rs2)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      ld_cnt <= '0;
    end else begin
      state  <= state_nxt;
      ld_cnt <= ld_cnt_nxt;
    end
  end

  // Priority: dmem freeze > EX busy > redirect > load-use stall
  always_comb begin
    state_nxt     = state;
    ld_cnt_nxt    = ld_cnt;
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    if_id_flush   = 1'b0;
    im_flush      = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_flush  = 1'b0;
    mem_wb_flush  = 1'b0;
    load_stall    = 1'b0;
    redirect_take = 1'b0;
    if (!rst) begin
      if (dmem_wait) begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_flush = 1'b1;
        load_stall   = (state == LD_STALL);
      end else if (ex_busy) begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_flush = 1'b1;
        load_stall   = (state == LD_STALL);
      end else if (modify_pc_ex) begin
        if_id_flush   = 1'b1;
        im_flush      = 1'b1;
        id_ex_flush   = 1'b1;
        redirect_take = 1'b1;
        state_nxt     = RUN;
        ld_cnt_nxt    = '0;
      end else if (hz || (state == LD_STALL)) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
        load_stall  = 1'b1;
        if (state == RUN) begin
          if (LOAD_USE_CYCLES > 1) begin
            state_nxt  = LD_STALL;
            ld_cnt_nxt = LD_INIT;
          end
        end else if (ld_cnt <= LD_CNT_W'(1)) begin
          state_nxt  = RUN;
          ld_cnt_nxt = '0;
        end else begin
          ld_cnt_nxt = ld_cnt - LD_CNT_W'(1);
        end
      end
    end
  end

  sat_counter #(.W(PERF_CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (!pc_en),
    .cnt (stall_cnt)
  );

  sat_counter #(.W(PERF_CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (redirect_take),
    .cnt (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Scoreboard bench: two controllers (1 and 3 load-use cycles) share stimulus;
// the driver queues hand-computed expectations, a negedge monitor checks them.
module tb_hazard_ctrl_mc;
  import riscv_pkg::*;

  // Output vector order: pc,if_id,id_ex,ex_mem enables | if_id,im,id_ex,ex_mem,mem_wb flushes | load_stall
  localparam logic [9:0] DEF  = 10'b1111_00000_0;
  localparam logic [9:0] STL  = 10'b0011_00100_1;
  localparam logic [9:0] FRZ  = 10'b0000_00001_0;
  localparam logic [9:0] FRZL = 10'b0000_00001_1;
  localparam logic [9:0] BSY  = 10'b0001_00010_0;
  localparam logic [9:0] RDR  = 10'b1111_11100_0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic [6:0] opcode_id = '0;
  logic       ex_load_inst = 1'b0, modify_pc_ex = 1'b0, ex_busy = 1'b0, dmem_wait = 1'b0;

  logic        a_pc, a_ifid, a_idex, a_exmem, a_fifid, a_fim, a_fidex, a_fexmem, a_fmemwb, a_ls;
  logic        b_pc, b_ifid, b_idex, b_exmem, b_fifid, b_fim, b_fidex, b_fexmem, b_fmemwb, b_ls;
  logic [31:0] a_scnt, a_fcnt, b_scnt, b_fcnt;
  logic [9:0]  act_a, act_b;

  assign act_a = {a_pc, a_ifid, a_idex, a_exmem, a_fifid, a_fim, a_fidex, a_fexmem, a_fmemwb, a_ls};
  assign act_b = {b_pc, b_ifid, b_idex, b_exmem, b_fifid, b_fim, b_fidex, b_fexmem, b_fmemwb, b_ls};

  always #5 clk = ~clk;

  hazard_ctrl_mc #(.LOAD_USE_CYCLES(1), .REG_ADDR_W(5), .PERF_CNT_W(32)) u_a (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .opcode_id(opcode_id),
    .ex_rd(ex_rd), .ex_load_inst(ex_load_inst), .modify_pc_ex(modify_pc_ex),
    .ex_busy(ex_busy), .dmem_wait(dmem_wait),
    .pc_en(a_pc), .if_id_en(a_ifid), .id_ex_en(a_idex), .ex_mem_en(a_exmem),
    .if_id_flush(a_fifid), .im_flush(a_fim), .id_ex_flush(a_fidex),
    .ex_mem_flush(a_fexmem), .mem_wb_flush(a_fmemwb), .load_stall(a_ls),
    .stall_cnt(a_scnt), .flush_cnt(a_fcnt)
  );

  hazard_ctrl_mc #(.LOAD_USE_CYCLES(3), .REG_ADDR_W(5), .PERF_CNT_W(32)) u_b (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .opcode_id(opcode_id),
    .ex_rd(ex_rd), .ex_load_inst(ex_load_inst), .modify_pc_ex(modify_pc_ex),
    .ex_busy(ex_busy), .dmem_wait(dmem_wait),
    .pc_en(b_pc), .if_id_en(b_ifid), .id_ex_en(b_idex), .ex_mem_en(b_exmem),
    .if_id_flush(b_fifid), .im_flush(b_fim), .id_ex_flush(b_fidex),
    .ex_mem_flush(b_fexmem), .mem_wb_flush(b_fmemwb), .load_stall(b_ls),
    .stall_cnt(b_scnt), .flush_cnt(b_fcnt)
  );

  typedef struct packed {
    logic [9:0]  oa, ob;
    logic [31:0] sa, fa, sb, fb;
    logic [7:0]  tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec    = 0;

  task automatic chk(input string nm, input int t, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d actual=%h expected=%h", nm, t, act, exp);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare against the queued entry
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("outs_luc1", int'(e.tag), 32'(act_a), 32'(e.oa));
      chk("outs_luc3", int'(e.tag), 32'(act_b), 32'(e.ob));
      chk("stall_cnt_luc1", int'(e.tag), a_scnt, e.sa);
      chk("flush_cnt_luc1", int'(e.tag), a_fcnt, e.fa);
      chk("stall_cnt_luc3", int'(e.tag), b_scnt, e.sb);
      chk("flush_cnt_luc3", int'(e.tag), b_fcnt, e.fb);
    end
  end

  task automatic cyc(input logic r, input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input logic ld, input logic mpc, input logic bsy, input logic dw,
                     input logic [9:0] oa, input logic [9:0] ob,
                     input int sa, input int fa, input int sb, input int fb);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; opcode_id = op; id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd;
    ex_load_inst = ld; modify_pc_ex = mpc; ex_busy = bsy; dmem_wait = dw;
    e.oa = oa; e.ob = ob;
    e.sa = 32'(sa); e.fa = 32'(fa); e.sb = 32'(sb); e.fb = 32'(fb);
    e.tag = 8'(vec);
    q.push_back(e);
    vec++;
  endtask

  task automatic idle(input logic [9:0] oa, input logic [9:0] ob,
                      input int sa, input int fa, input int sb, input int fb);
    cyc(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, oa, ob, sa, fa, sb, fb);
  endtask

  initial begin
    // Reset held while a hazard is presented: defaults only
    cyc(1'b1, RTYPE, 5'd0, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, DEF, DEF, 0, 0, 0, 0);
    // Load-use on rs2: one bubble for LUC=1, three for LUC=3
    cyc(1'b0, RTYPE, 5'd0, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, STL, STL, 0, 0, 0, 0);
    idle(DEF, STL, 1, 0, 1, 0);
    idle(DEF, STL, 1, 0, 2, 0);
    idle(DEF, DEF, 1, 0, 3, 0);
    // Same hazard, dmem_wait for 2 cycles in the 2nd stall cycle
    cyc(1'b0, RTYPE, 5'd0, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, STL, STL, 1, 0, 3, 0);
    cyc(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, FRZ, FRZL, 2, 0, 4, 0);
    cyc(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, FRZ, FRZL, 3, 0, 5, 0);
    idle(DEF, STL, 4, 0, 6, 0);
    idle(DEF, STL, 4, 0, 7, 0);
    idle(DEF, DEF, 4, 0, 8, 0);
    // Redirect together with an rs1 hazard: redirect wins
    cyc(1'b0, ITYPE, 5'd7, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, RDR, RDR, 4, 0, 8, 0);
    idle(DEF, DEF, 4, 1, 8, 1);
    // EX busy for 4 cycles
    for (int i = 0; i < 4; i++)
      cyc(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, BSY, BSY, 4 + i, 1, 8 + i, 1);
    idle(DEF, DEF, 8, 1, 12, 1);
    // dmem_wait with a redirect: redirect deferred to the next cycle
    cyc(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, FRZ, FRZ, 8, 1, 12, 1);
    cyc(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, RDR, RDR, 9, 1, 13, 1);
    idle(DEF, DEF, 9, 2, 13, 2);
    // Redirect during a multi-cycle stall ends it
    cyc(1'b0, RTYPE, 5'd0, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, STL, STL, 9, 2, 13, 2);
    cyc(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, RDR, RDR, 10, 2, 14, 2);
    idle(DEF, DEF, 10, 3, 14, 3);
    // Async reset in the 2nd stall cycle
    cyc(1'b0, RTYPE, 5'd0, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, STL, STL, 10, 3, 14, 3);
    cyc(1'b1, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, DEF, DEF, 0, 0, 0, 0);
    idle(DEF, DEF, 0, 0, 0, 0);
    // x0 destination and non-reading opcode never stall
    cyc(1'b0, RTYPE, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, DEF, DEF, 0, 0, 0, 0);
    cyc(1'b0, LUI, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, DEF, DEF, 0, 0, 0, 0);
    // Store data (rs2) hazard
    cyc(1'b0, STYPE, 5'd0, 5'd3, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, STL, STL, 0, 0, 0, 0);
    idle(DEF, STL, 1, 0, 1, 0);
    idle(DEF, STL, 1, 0, 2, 0);
    idle(DEF, DEF, 1, 0, 3, 0);

    repeat (2) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d pending expected=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_mc.md
# hazard_ctrl_mc

Parametrised pipeline hazard controller for the 5-stage RV32I core. It is the successor to the single-cycle load-use/redirect unit. It generates per-stage enables and flushes for four cases: EX-resolved control redirects, multi-cycle load-use stalls (for data memories with read latency above one), multi-cycle EX operations (mul/div busy), and data-memory wait states. It also keeps saturating stall and flush performance counters.

## Interface
Parameters:
- LOAD_USE_CYCLES, 1, total bubble cycles inserted per load-use hazard (1..7)
- REG_ADDR_W, 5, register-index width
- PERF_CNT_W, 32, width of perf counters

Ports:
- clk  input  1  core clock. One clock domain; reset is asynchronous and active-high.
- rst  input  1  asynchronous, active-high reset
- id_rs1, id_rs2  input  REG_ADDR_W  source registers of the instruction in ID
- opcode_id  input  7  opcode in ID; decides rs1/rs2 usage
- ex_rd  input  REG_ADDR_W  rd of the instruction in EX
- ex_load_inst  input  1  instruction in EX is a load
- modify_pc_ex  input  1  branch/jump redirect resolved in EX
- ex_busy  input  1  multi-cycle EX unit has not finished
- dmem_wait  input  1  data memory not ready for the access in MEM
- pc_en, if_id_en, id_ex_en, ex_mem_en  output  1  stage register enables
- if_id_flush, im_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  output  1  bubble insertion
- load_stall  output  1  a load-use stall is active this cycle
- stall_cnt  output  PERF_CNT_W  cycles with pc_en=0
- flush_cnt  output  PERF_CNT_W  accepted redirects

## Operation
Usage decode:
- rs1 is used by RTYPE, ITYPE, ILOAD, STYPE, BTYPE, IJALR.
- rs2 is used by RTYPE, STYPE, BTYPE.

Load-use hazard (hz):
- hz = ex_load_inst & ex_rd≠0 & ((rs1_used & ex_rd==id_rs1) | (rs2_used & ex_rd==id_rs2)).

FSM, two states:
- RUN → LD_STALL when hz is accepted and LOAD_USE_CYCLES>1; ld_cnt loads LOAD_USE_CYCLES-1.
- In LD_STALL, ld_cnt decrements on each non-frozen cycle.
- LD_STALL → RUN when ld_cnt reaches 1 and that cycle is not frozen, or when a redirect is accepted (ld_cnt cleared).

Priority is evaluated every cycle; defaults are all enables 1 and all flushes 0.
1. dmem_wait (freeze):
   - pc_en, if_id_en, id_ex_en, ex_mem_en = 0.
   - mem_wb_flush = 1.
   - All other flushes = 0; FSM and ld_cnt hold.
2. ex_busy:
   - pc_en, if_id_en, id_ex_en = 0; ex_mem_flush = 1.
   - FSM holds.
3. modify_pc_ex:
   - if_id_flush, im_flush, id_ex_flush = 1; pc_en = 1.
   - FSM forced to RUN; flush_cnt increments.
4. hz in RUN, or any cycle in LD_STALL:
   - pc_en, if_id_en = 0; id_ex_flush = 1; load_stall = 1.

Counters:
- stall_cnt increments on each cycle with pc_en=0. flush_cnt increments as stated in case 3.
- Both saturate at all-ones and reset to 0.

## Timing
- All enable and flush outputs are combinational from inputs and current state, with zero-cycle latency.
- FSM, ld_cnt and counters update on the rising edge of clk.
- During reset, outputs take the default values:
  - enables = 1, flushes = 0, load_stall = 0.
  - state = RUN, ld_cnt = 0, stall_cnt = flush_cnt = 0.
- A load-use hazard produces exactly LOAD_USE_CYCLES consecutive load_stall cycles, not counting cycles frozen by dmem_wait or ex_busy. Those frozen cycles extend the window without consuming it.
- A redirect arriving in the same cycle as hz wins; the stall is not entered.
- If dmem_wait and modify_pc_ex arrive together, no flush is issued. The branch stays in EX and the redirect is taken on the first cycle after dmem_wait falls.
- Asserting rst mid-stall returns the FSM to RUN immediately (asynchronous); outputs go to defaults in the same cycle.

## Structure
- Opcode, FORWARD, LOAD and STORE defines move into the shared package riscv_pkg. hazard_ctrl_mc imports it.
- The FSM state enum (RUN, LD_STALL) belongs in the same package.
- One sub-module, sat_counter (parameter W, inputs inc/clk/rst), is instantiated twice for the perf counters.
- Remaining logic is flat: roughly 200 lines.

## Test plan
- LOAD_USE_CYCLES=1, ex_load_inst=1, ex_rd=5, opcode_id=RTYPE, id_rs2=5 → one cycle with pc_en=0, if_id_en=0, id_ex_flush=1, load_stall=1; stall_cnt=1.
- LOAD_USE_CYCLES=3, same hazard → load_stall high for exactly 3 consecutive cycles, then RUN; stall_cnt=3.
- LOAD_USE_CYCLES=3, dmem_wait pulsed for 2 cycles in the 2nd stall cycle → load_stall spans 5 cycles; mem_wb_flush=1 only during the 2 wait cycles.
- modify_pc_ex=1 with a simultaneous hz (ex_rd=7, id_rs1=7, ITYPE) → if_id_flush, id_ex_flush and im_flush all =1, pc_en=1, load_stall=0, flush_cnt=1.
- ex_busy held 4 cycles with no other events → pc_en, if_id_en and id_ex_en =0 and ex_mem_flush=1 for 4 cycles; stall_cnt=4.
- rst asserted in the 2nd LD_STALL cycle → outputs return to defaults immediately and counters are 0; ex_rd=0 with a load never stalls.
